// File: rtl/c_element_join.sv
// c_element_join: clocked 4-phase join of N request lanes (C-element behaviour).
// Ports: clk, rst (sync, active-high), in[N] async requests, mask[N] lane
//   enables, ack_i downstream ack, err_clr; out joined request, ack_o lane ack,
//   err sticky protocol flag, count completed 4-phase cycles (wraps).
module c_element_join #(
    parameter int   N           = 2,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0,
    parameter int   CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    input  logic [N-1:0]     mask,
    input  logic             ack_i,
    input  logic             err_clr,
    output logic             out,
    output logic             ack_o,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    // Encoding chosen so out = state[0] and ack_o = state[1]; both come
    // straight from the state register with no decode glitches.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RISE  = 2'b01,
        ACKED = 2'b11,
        FALL  = 2'b10
    } state_t;

    localparam state_t RST_STATE = INIT ? ACKED : IDLE;

    state_t           state_q;
    state_t           state_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [N-1:0]     s;
    logic             any_en;
    logic             any_lo;
    logic             any_hi;
    logic             all_hi;
    logic             all_lo;

    // Per-lane synchronizers for the asynchronous request levels.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [N-1:0] sq [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sq[i] <= {N{INIT}};
                    end
                end else begin
                    sq[0] <= in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sq[i] <= sq[i-1];
                    end
                end
            end

            assign s = sq[SYNC_STAGES-1];
        end
    endgenerate

    // Masked-off lanes never block either phase; an all-zero mask makes
    // both conditions false so the handshake freezes.
    assign any_en = |mask;
    assign any_lo = |(~s & mask);
    assign any_hi = |(s & mask);
    assign all_hi = any_en & ~any_lo;
    assign all_lo = any_en & ~any_hi;

    always_comb begin
        state_d = state_q;
        err_d   = err_q & ~err_clr;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (all_hi) state_d = RISE;
            end
            RISE: begin
                if (ack_i)       state_d = ACKED;
                else if (any_lo) err_d   = 1'b1;
            end
            ACKED: begin
                if (all_lo) state_d = FALL;
            end
            FALL: begin
                if (!ack_i) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end else if (any_hi) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out   = state_q[0];
    assign ack_o = state_q[1];
    assign err   = err_q;
    assign count = cnt_q;

endmodule
